// File: rtl/elut_bank_pkg.sv
// elut_bank_pkg: shared definitions for the elut_bank logic-cell primitive.
// Holds the default LUT input count, the loader state encodings and a small
// helper that gives the terminal load address for a K-input table.
package elut_bank_pkg;

    // Default number of LUT inputs (K); table depth is 2^K.
    localparam int ZUMA_LUT_SIZE_DEFAULT = 6;

    // Loader state encodings, kept numerically stable for older fabric tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Highest table address for a K-input LUT (2^K - 1).
    function automatic int unsigned last_addr(input int unsigned k);
        return (32'd1 << k) - 32'd1;
    endfunction

endpackage

// File: rtl/elut_bank_cell.sv
// elut_bank_cell: one 2^K-bit LUT table with a single-bit synchronous write
// port and an asynchronous (combinational) read port.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address (K bits)
//   wbit  - bit written at waddr
//   raddr - read address (K bits)
//   rdata - raw table bit at raddr, no gating
module elut_bank_cell
    import elut_bank_pkg::*;
#(
    parameter int                          K    = ZUMA_LUT_SIZE_DEFAULT,
    parameter logic [(2**K)-1:0]           INIT = {(2**K){1'b0}}
) (
    input  logic         clk,
    input  logic         we,
    input  logic [K-1:0] waddr,
    input  logic         wbit,
    input  logic [K-1:0] raddr,
    output logic         rdata
);

    // Behaves like LUTRAM: power-up contents come from INIT and no reset
    // ever touches the table.
    logic [(2**K)-1:0] table_r = INIT;

    // Single-bit table write on the configuration clock.
    always_ff @(posedge clk) begin
        if (we) begin
            table_r[waddr] <= wbit;
        end
    end

    assign rdata = table_r[raddr];

endmodule

// File: rtl/elut_bank.sv
// elut_bank: bank of NUM_LUTS writable K-input LUTs sharing one streaming
// configuration port. A loader FSM walks the table address from 0 to 2^K-1,
// writing bit i of each accepted beat into LUT i.
// Ports:
//   clk       - sole clock
//   rst       - synchronous active-high reset (table contents survive)
//   cfg_start - begin (or restart) a full reload from address 0
//   cfg_valid - cfg_data beat valid
//   cfg_ready - bank accepts a beat (loader in LOAD)
//   cfg_data  - one bit per LUT for the current load address
//   cfg_busy  - loader in LOAD
//   cfg_done  - a full load has completed since the last start or reset
//   lut_in    - read address of LUT i at [i*K +: K]
//   q_en      - capture enable for lut_q
//   lut_out   - combinational LUT outputs, forced to 0 while loading
//   lut_q     - registered LUT outputs, cleared by rst and while loading
module elut_bank
    import elut_bank_pkg::*;
#(
    parameter int                                    ZUMA_LUT_SIZE = ZUMA_LUT_SIZE_DEFAULT,
    parameter int                                    NUM_LUTS      = 8,
    parameter logic [NUM_LUTS*(2**ZUMA_LUT_SIZE)-1:0] INIT_MASK    =
        {(NUM_LUTS*(2**ZUMA_LUT_SIZE)){1'b0}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_start,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [NUM_LUTS-1:0]               cfg_data,
    output logic                              cfg_busy,
    output logic                              cfg_done,
    input  logic [NUM_LUTS*ZUMA_LUT_SIZE-1:0] lut_in,
    input  logic                              q_en,
    output logic [NUM_LUTS-1:0]               lut_out,
    output logic [NUM_LUTS-1:0]               lut_q
);

    localparam int K     = ZUMA_LUT_SIZE;
    localparam int DEPTH = 2**K;

    // Address counter carries one spare bit; the terminal beat is detected at
    // 2^K-1 so the count never wraps back onto address 0.
    localparam logic [K:0] LAST_ADDR = (K+1)'(last_addr(K));
    localparam logic [K:0] ADDR_ONE  = {{K{1'b0}}, 1'b1};
    localparam logic [K:0] ADDR_ZERO = {(K+1){1'b0}};

    logic [1:0]          state_r;
    logic [K:0]          addr_r;
    logic                busy_s;
    logic                we_s;
    logic [NUM_LUTS-1:0] raw_s;
    logic [NUM_LUTS-1:0] raw_clean_s;
    logic [NUM_LUTS-1:0] lut_out_s;

    assign busy_s    = (state_r == ST_LOAD);
    assign cfg_busy  = busy_s;
    assign cfg_ready = busy_s;
    assign cfg_done  = (state_r == ST_DONE);

    // A restart cycle never writes, and reset suppresses any in-flight beat.
    assign we_s = busy_s & cfg_valid & ~cfg_start & ~rst;

    // Loader FSM and load address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= ADDR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_r <= ST_LOAD;
                        addr_r  <= ADDR_ZERO;
                    end
                end
                ST_LOAD: begin
                    if (cfg_start) begin
                        addr_r <= ADDR_ZERO;
                    end else if (cfg_valid) begin
                        addr_r <= addr_r + ADDR_ONE;
                        if (addr_r == LAST_ADDR) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (cfg_start) begin
                        state_r <= ST_LOAD;
                        addr_r  <= ADDR_ZERO;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    addr_r  <= ADDR_ZERO;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
        elut_bank_cell #(
            .K    (K),
            .INIT (INIT_MASK[g*DEPTH +: DEPTH])
        ) u_cell (
            .clk   (clk),
            .we    (we_s),
            .waddr (addr_r[K-1:0]),
            .wbit  (cfg_data[g]),
            .raddr (lut_in[g*K +: K]),
            .rdata (raw_s[g])
        );
    end

    // Map unknown table bits to 0 in simulation so X never leaks to the fabric.
    always_comb begin
        raw_clean_s = raw_s;
`ifdef SIMULATION
        for (int i = 0; i < NUM_LUTS; i++) begin
            raw_clean_s[i] = (raw_s[i] === 1'b1) ? 1'b1 : 1'b0;
        end
`endif
    end

    // Outputs read as 0 while the tables are being rewritten.
    assign lut_out_s = busy_s ? {NUM_LUTS{1'b0}} : raw_clean_s;
    assign lut_out   = lut_out_s;

    // Registered LUT outputs with capture enable.
    always_ff @(posedge clk) begin
        if (rst || busy_s) begin
            lut_q <= {NUM_LUTS{1'b0}};
        end else if (q_en) begin
            lut_q <= lut_out_s;
        end
    end

endmodule

// File: tb/tb_elut_bank.sv
// tb_elut_bank: self-checking bench for elut_bank (K=6, NUM_LUTS=8).
// The reference model is a 64-entry array of 8-bit columns: entry a holds the
// bit each LUT stores at address a, updated from every accepted beat.
module tb_elut_bank;

    localparam int K     = 6;
    localparam int N     = 8;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_start;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [N-1:0]   cfg_data;
    logic           cfg_busy;
    logic           cfg_done;
    logic [N*K-1:0] lut_in;
    logic           q_en;
    logic [N-1:0]   lut_out;
    logic [N-1:0]   lut_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [DEPTH];

    elut_bank #(.ZUMA_LUT_SIZE(K), .NUM_LUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .lut_in    (lut_in),
        .q_en      (q_en),
        .lut_out   (lut_out),
        .lut_q     (lut_q)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected combinational output: LUT i looks up its own column bit.
    function automatic logic [N-1:0] model_read(input logic [N*K-1:0] in);
        logic [N-1:0] r;
        logic [7:0]   col;
        for (int i = 0; i < N; i++) begin
            col  = model_mem[in[i*K +: K]];
            r[i] = col[i];
        end
        return r;
    endfunction

    function automatic logic [N*K-1:0] rand_in();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[N*K-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        q_en = 1'b1; lut_in = '0;
        step(); step();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/busy/done=%b want 000", {cfg_ready, cfg_busy, cfg_done});
        end
        n_tests++;
        if (lut_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lut_q: got %h want 00", lut_q);
        end
        for (int j = 0; j < 6; j++) begin
            lut_in = rand_in();
            #1;
            n_tests++;
            if (lut_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_lut_out: in=%h got %h want 00", lut_in, lut_out);
            end
        end
    endtask

    task automatic test_full_load();
        logic [N-1:0] exp;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        n_tests++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL load_enter: got ready/busy/done=%b want 110", {cfg_ready, cfg_busy, cfg_done});
        end
        for (int a = 0; a < DEPTH; a++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'(a) ^ 8'hA5;
            step();
            model_mem[a] = 8'(a) ^ 8'hA5;
            if (a < DEPTH - 1) begin
                if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
                    n_tests++; n_fail++;
                    $display("FAIL load_progress: beat %0d done=%b ready=%b want 0 1", a, cfg_done, cfg_ready);
                end
            end else begin
                n_tests++;
                if (cfg_done !== 1'b1 || cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_done: done=%b ready=%b want 1 0", cfg_done, cfg_ready);
                end
            end
        end
        cfg_valid = 1'b0;
        lut_in = {N{6'd5}};
        #1;
        n_tests++;
        if (lut_out !== 8'hA0) begin
            n_fail++;
            $display("FAIL load_addr5: got %h want a0", lut_out);
        end
        for (int j = 0; j < 8; j++) begin
            lut_in = rand_in();
            #1;
            exp = model_read(lut_in);
            n_tests++;
            if (lut_out !== exp) begin
                n_fail++;
                $display("FAIL load_read: in=%h got %h want %h", lut_in, lut_out, exp);
            end
        end
    endtask

    task automatic test_back_pressure();
        int cyc;
        int beats;
        logic [7:0] d;
        logic [N-1:0] exp;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cyc = 0; beats = 0;
        // Invalid cycles carry garbage that must never reach the tables.
        while (cfg_done !== 1'b1 && cyc < 300) begin
            d = 8'($urandom);
            cfg_valid = (cyc % 2) == 1;
            cfg_data  = d;
            step();
            if ((cyc % 2) == 1 && beats < DEPTH) begin
                model_mem[beats] = d;
                beats++;
            end
            cyc++;
        end
        cfg_valid = 1'b0;
        n_tests++;
        if (cyc !== 128) begin
            n_fail++;
            $display("FAIL bp_cycles: got %0d want 128", cyc);
        end
        for (int a = 0; a < DEPTH; a++) begin
            lut_in = {N{6'(a)}};
            #1;
            exp = model_read(lut_in);
            n_tests++;
            if (lut_out !== exp) begin
                n_fail++;
                $display("FAIL bp_contents: addr=%0d got %h want %h", a, lut_out, exp);
            end
        end
    endtask

    task automatic test_register();
        logic [N-1:0] prev;
        logic [N-1:0] held;
        q_en = 1'b1;
        lut_in = rand_in();
        #1;
        prev = model_read(lut_in);
        for (int j = 0; j < 10; j++) begin
            step();
            n_tests++;
            if (lut_q !== prev) begin
                n_fail++;
                $display("FAIL reg_capture: cycle %0d got %h want %h", j, lut_q, prev);
            end
            lut_in = rand_in();
            #1;
            prev = model_read(lut_in);
        end
        step();
        held = prev;
        q_en = 1'b0;
        for (int j = 0; j < 6; j++) begin
            lut_in = rand_in();
            step();
            n_tests++;
            if (lut_q !== held) begin
                n_fail++;
                $display("FAIL reg_hold: cycle %0d got %h want %h", j, lut_q, held);
            end
        end
        q_en = 1'b1;
    endtask

    task automatic test_restart();
        logic [7:0] d;
        logic [N-1:0] exp;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int a = 0; a < 20; a++) begin
            d = 8'($urandom);
            cfg_valid = 1'b1;
            cfg_data  = d;
            lut_in    = rand_in();
            step();
            model_mem[a] = d;
            n_tests++;
            if (lut_out !== 8'h00 || lut_q !== 8'h00) begin
                n_fail++;
                $display("FAIL load_gating: beat %0d lut_out=%h lut_q=%h want 00 00", a, lut_out, lut_q);
            end
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        step();
        cfg_start = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            d = 8'($urandom);
            cfg_data = d;
            step();
            model_mem[a] = d;
            n_tests++;
            if (cfg_done !== ((a == DEPTH - 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL restart_done: beat %0d done=%b want %b", a, cfg_done, a == DEPTH - 1);
            end
        end
        cfg_valid = 1'b0;
        lut_in = {N{6'd0}};
        #1;
        n_tests++;
        if (lut_out !== model_mem[0]) begin
            n_fail++;
            $display("FAIL restart_addr0: got %h want %h", lut_out, model_mem[0]);
        end
        for (int j = 0; j < 6; j++) begin
            lut_in = rand_in();
            #1;
            exp = model_read(lut_in);
            n_tests++;
            if (lut_out !== exp) begin
                n_fail++;
                $display("FAIL restart_read: in=%h got %h want %h", lut_in, lut_out, exp);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        logic [N-1:0] exp;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int a = 0; a < 30; a++) begin
            d = 8'($urandom);
            cfg_valid = 1'b1;
            cfg_data  = d;
            step();
            model_mem[a] = d;
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_flags: got ready/busy/done=%b want 000", {cfg_ready, cfg_busy, cfg_done});
        end
        for (int a = 0; a < DEPTH; a++) begin
            lut_in = {N{6'(a)}};
            #1;
            exp = model_read(lut_in);
            n_tests++;
            if (lut_out !== exp) begin
                n_fail++;
                $display("FAIL midrst_contents: addr=%0d got %h want %h", a, lut_out, exp);
            end
        end
        // Reset and start on the same edge: reset wins, loader stays idle.
        rst = 1'b1;
        cfg_start = 1'b1;
        step();
        rst = 1'b0;
        cfg_start = 1'b0;
        n_tests++;
        if (cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_vs_start: busy=%b want 0", cfg_busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_back_pressure();
        test_register();
        test_restart();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
